// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a start/done handshake.
// Single-cycle ops complete at the accepting edge. MUL (shift-add) and
// DIV (restoring) iterate once per clock for LEN clocks.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// RUN   | multi-cycle MUL/DIV iterating, counter counts down to 0
module seq_alu #(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [3:0]     code,
  input  logic [LEN-1:0] A,
  input  logic [LEN-1:0] B,
  output logic [LEN-1:0] out,
  output logic [LEN-1:0] out_hi,
  output logic           done,
  output logic           busy,
  output logic [3:0]     flags,
  output logic           err
);

  localparam int CNT_W = $clog2(LEN) + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LEN-1:0]   a_q;
  logic [LEN-1:0]   b_q;
  logic             is_div;
  // MUL: hi_q = partial product high half, lo_q = multiplier shifting out / product low half.
  // DIV: hi_q = partial remainder, lo_q = dividend shifting out / quotient shifting in.
  logic [LEN-1:0]   hi_q;
  logic [LEN-1:0]   lo_q;

  logic [LEN:0]     sum;
  logic [LEN:0]     diff;
  logic [LEN-1:0]   s_out;
  logic [LEN-1:0]   s_hi;
  logic             s_c;
  logic             s_v;
  logic             s_err;
  logic             s_multi;
  logic [3:0]       s_flags;

  logic [LEN:0]     madd;
  logic [LEN:0]     d_sh;
  logic [LEN:0]     d_diff;
  logic             d_ge;
  logic [LEN-1:0]   n_hi;
  logic [LEN-1:0]   n_lo;

  // Single-cycle result, flags and multi-cycle dispatch decision from the live inputs
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    s_out   = '0;
    s_hi    = '0;
    s_c     = 1'b0;
    s_v     = 1'b0;
    s_err   = 1'b0;
    s_multi = 1'b0;
    case (code)
      OP_ADD: begin
        s_out = sum[LEN-1:0];
        s_c   = sum[LEN];
        s_v   = (A[LEN-1] == B[LEN-1]) && (sum[LEN-1] != A[LEN-1]);
      end
      OP_SUB: begin
        s_out = diff[LEN-1:0];
        s_c   = diff[LEN];
        s_v   = (A[LEN-1] != B[LEN-1]) && (diff[LEN-1] != A[LEN-1]);
      end
      OP_AND:  s_out = A & B;
      OP_OR:   s_out = A | B;
      OP_XOR:  s_out = A ^ B;
      OP_NOT:  s_out = ~A;
      OP_SHL: begin
        s_out = {A[LEN-2:0], 1'b0};
        s_c   = A[LEN-1];
      end
      OP_SHR: begin
        s_out = {1'b0, A[LEN-1:1]};
        s_c   = A[0];
      end
      OP_PASS: s_out = B;
      OP_MUL:  s_multi = 1'b1;
      OP_DIV: begin
        // Divide by zero short-circuits to a saturated quotient instead of iterating.
        if (B == '0) begin
          s_out = '1;
          s_hi  = A;
          s_v   = 1'b1;
        end else begin
          s_multi = 1'b1;
        end
      end
      default: s_err = 1'b1;
    endcase
    // Illegal opcodes report all-zero flags, including Z.
    s_flags = s_err ? 4'b0000 : {s_out[LEN-1], (s_out == '0), s_c, s_v};
  end

  // One MUL or DIV iteration computed from the held partial state
  always_comb begin
    madd   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
    d_sh   = {hi_q, lo_q[LEN-1]};
    d_diff = d_sh - {1'b0, b_q};
    // Remainder stays below the divisor, so the top bit of the difference is a clean borrow.
    d_ge   = ~d_diff[LEN];
    if (is_div) begin
      n_hi = d_ge ? d_diff[LEN-1:0] : d_sh[LEN-1:0];
      n_lo = {lo_q[LEN-2:0], d_ge};
    end else begin
      n_hi = madd[LEN:1];
      n_lo = {madd[0], lo_q[LEN-1:1]};
    end
  end

  // Control FSM with registered results and handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      is_div <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      out    <= '0;
      out_hi <= '0;
      flags  <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (s_multi) begin
              a_q    <= A;
              b_q    <= B;
              is_div <= (code == OP_DIV);
              hi_q   <= '0;
              lo_q   <= (code == OP_DIV) ? A : B;
              cnt    <= CNT_W'(LEN);
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              out    <= s_out;
              out_hi <= s_hi;
              flags  <= s_flags;
              err    <= s_err;
              done   <= 1'b1;
            end
          end
        end
        RUN: begin
          hi_q <= n_hi;
          lo_q <= n_lo;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            out    <= n_lo;
            out_hi <= n_hi;
            flags  <= {n_lo[LEN-1], (n_lo == '0), (!is_div && (n_hi != '0)), 1'b0};
            err    <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed test for seq_alu with LEN=8. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_seq_alu;

  localparam int LEN = 8;

  logic           clk;
  logic           resetn;
  logic           start;
  logic [3:0]     code;
  logic [LEN-1:0] a;
  logic [LEN-1:0] b;
  logic [LEN-1:0] out;
  logic [LEN-1:0] out_hi;
  logic           done;
  logic           busy;
  logic [3:0]     flags;
  logic           err;

  int total = 0;
  int bad   = 0;

  seq_alu #(.LEN(LEN)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .code   (code),
    .A      (a),
    .B      (b),
    .out    (out),
    .out_hi (out_hi),
    .done   (done),
    .busy   (busy),
    .flags  (flags),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input int eo, input int eh, input int ef, input int ee);
    check({tag, ".out"},    32'(out),    32'(eo));
    check({tag, ".out_hi"}, 32'(out_hi), 32'(eh));
    check({tag, ".flags"},  32'(flags),  32'(ef));
    check({tag, ".err"},    32'(err),    32'(ee));
  endtask

  // Present one start for a single accepting edge, then scramble the operands
  // so a result that depends on late inputs shows up as wrong.
  task automatic issue(input logic [3:0] c, input logic [LEN-1:0] x, input logic [LEN-1:0] y);
    @(negedge clk);
    start = 1'b1;
    code  = c;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    code  = 4'd3;
    a     = ~x;
    b     = ~y;
  endtask

  // Count falling edges after the accepting edge until done; bounded.
  // Optionally poke a start (ADD 1+1) at falling edge 3 to confirm it is ignored.
  task automatic wait_done(input bit poke, output int n, output int busy_cnt);
    n = 1;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (poke && n == 3) begin
        start = 1'b1;
        code  = 4'd0;
        a     = 8'd1;
        b     = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    int bc;
    int dcount;
    logic [7:0] exp_out [9];
    logic [3:0] exp_fl  [9];
    exp_out = '{8'd5, 8'd3, 8'd0, 8'd5, 8'd5, 8'd251, 8'd8, 8'd2, 8'd1};
    exp_fl  = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};

    resetn = 1'b0;
    start  = 1'b0;
    code   = '0;
    a      = '0;
    b      = '0;
    #2;
    check_res("reset", 0, 0, 0, 0);
    check("reset.done", 32'(done), 0);
    check("reset.busy", 32'(busy), 0);
    @(negedge clk);
    resetn = 1'b1;

    // ADD with carry out
    issue(4'd0, 8'd200, 8'd100);
    wait_done(1'b0, n, bc);
    check("add_c.lat", 32'(n), 1);
    check_res("add_c", 44, 0, 4'b0010, 0);

    issue(4'd1, 8'd4, 8'd1);
    wait_done(1'b0, n, bc);
    check_res("sub", 3, 0, 4'b0000, 0);

    // Signed overflow, negative result
    issue(4'd0, 8'd100, 8'd100);
    wait_done(1'b0, n, bc);
    check_res("add_v", 200, 0, 4'b1001, 0);

    issue(4'd1, 8'd5, 8'd5);
    wait_done(1'b0, n, bc);
    check_res("sub_z", 0, 0, 4'b0100, 0);

    // Codes 0-8 back to back, one accept per cycle
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("b2b%0d.done", i - 1), 32'(done), 1);
        check($sformatf("b2b%0d.out", i - 1), 32'(out), 32'(exp_out[i-1]));
        check($sformatf("b2b%0d.flags", i - 1), 32'(flags), 32'(exp_fl[i-1]));
      end
      start = 1'b1;
      code  = 4'(i);
      a     = 8'd4;
      b     = 8'd1;
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b8.done", 32'(done), 1);
    check("b2b8.out", 32'(out), 32'(exp_out[8]));
    check("b2b8.flags", 32'(flags), 32'(exp_fl[8]));
    @(negedge clk);
    check("b2b_end.done", 32'(done), 0);

    // MUL 20*20 = 0x190, with a start poked while busy
    issue(4'd9, 8'd20, 8'd20);
    wait_done(1'b1, n, bc);
    check("mul.lat", 32'(n), 32'(LEN + 1));
    check("mul.busy_cycles", 32'(bc), 32'(LEN));
    check("mul.busy_at_done", 32'(busy), 0);
    check_res("mul", 8'h90, 8'h01, 4'b1010, 0);
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("mul.extra_done", 32'(dcount), 0);
    check("mul.hold_out", 32'(out), 32'h90);

    // DIV 100/7
    issue(4'd10, 8'd100, 8'd7);
    wait_done(1'b0, n, bc);
    check("div.lat", 32'(n), 32'(LEN + 1));
    check_res("div", 14, 2, 4'b0000, 0);

    // Divide by zero completes as a single-cycle op
    issue(4'd10, 8'd9, 8'd0);
    check("div0.busy", 32'(busy), 0);
    wait_done(1'b0, n, bc);
    check("div0.lat", 32'(n), 1);
    check_res("div0", 8'hFF, 9, 4'b1001, 0);

    // Illegal opcode, then a legal op clears err
    issue(4'd12, 8'd5, 8'd3);
    wait_done(1'b0, n, bc);
    check("ill.lat", 32'(n), 1);
    check_res("ill", 0, 0, 4'b0000, 1);

    issue(4'd0, 8'd1, 8'd1);
    wait_done(1'b0, n, bc);
    check_res("add_after_ill", 2, 0, 4'b0000, 0);

    // Reset in the middle of a MUL aborts it
    issue(4'd9, 8'd20, 8'd20);
    repeat (3) @(negedge clk);
    check("abort.busy_before", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    check_res("abort", 0, 0, 0, 0);
    check("abort.busy", 32'(busy), 0);
    check("abort.done", 32'(done), 0);
    @(negedge clk);
    resetn = 1'b1;
    dcount = 0;
    repeat (LEN + 4) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("abort.no_done", 32'(dcount), 0);

    issue(4'd0, 8'd3, 8'd4);
    wait_done(1'b0, n, bc);
    check("post_abort.lat", 32'(n), 1);
    check_res("post_abort", 7, 0, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
